// File: rtl/dft_compute_stream.sv
`default_nettype none
// ============================================================================
//  Module      : dft_compute_stream
//  Description : N-point real-input fixed-point DFT engine. Buffers one frame
//                of N samples, then computes each bin X[k] serially with one
//                complex MAC per cycle. Twiddles come from an external cos/sin
//                ROM with a 1-cycle read latency. Real and imaginary parts leave
//                on independent valid/busy channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module dft_compute_stream #(
    parameter  int N      = 16,
    parameter  int LOG2N  = 4,
    parameter  int DATA_W = 16,
    parameter  int TW_W   = 16,
    localparam int OUT_W  = DATA_W + LOG2N + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     i_real_busy,
    input  logic                     i_real_vld,
    input  logic signed [DATA_W-1:0] i_real_data,
    input  logic                     o_dft_real_busy,
    output logic                     o_dft_real_vld,
    output logic signed [OUT_W-1:0]  o_dft_real_data,
    input  logic                     o_dft_imag_busy,
    output logic                     o_dft_imag_vld,
    output logic signed [OUT_W-1:0]  o_dft_imag_data,
    output logic [LOG2N-1:0]         o_bin_idx,
    output logic [LOG2N-1:0]         o_tw_addr,
    input  logic signed [TW_W-1:0]   i_tw_cos,
    input  logic signed [TW_W-1:0]   i_tw_sin
);

    localparam int               c_PROD_W  = DATA_W + TW_W;
    localparam int               c_ACC_W   = c_PROD_W + LOG2N;
    localparam logic [LOG2N-1:0] c_LAST    = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] c_ONE     = LOG2N'(1);
    localparam logic [LOG2N:0]   c_CYC_END = (LOG2N + 1)'(N);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic signed [DATA_W-1:0]   r_x [N];
    logic [LOG2N-1:0]           r_cnt;
    logic [LOG2N-1:0]           r_k;
    logic [LOG2N-1:0]           r_addr;
    logic [LOG2N:0]             r_cyc;
    logic signed [c_ACC_W-1:0]  r_acc_re;
    logic signed [c_ACC_W-1:0]  r_acc_im;
    logic                       r_busy;
    logic                       r_re_vld;
    logic                       r_im_vld;

    logic                       w_in_xfer;
    logic                       w_last_load;
    logic                       w_comp_end;
    logic                       w_re_xfer;
    logic                       w_im_xfer;
    logic                       w_bin_done;
    logic [LOG2N-1:0]           w_xidx;
    logic signed [DATA_W-1:0]   w_x_cur;
    logic signed [c_PROD_W-1:0] w_prod_re;
    logic signed [c_PROD_W-1:0] w_prod_im;
    logic signed [c_ACC_W-1:0]  w_prod_re_ext;
    logic signed [c_ACC_W-1:0]  w_prod_im_ext;
    logic                       w_unused;

    // Handshake qualifiers; a bin is finished once neither channel is still pending.
    assign w_in_xfer   = i_real_vld && !r_busy && (r_state == S_LOAD);
    assign w_last_load = w_in_xfer && (r_cnt == c_LAST);
    assign w_comp_end  = (r_state == S_COMPUTE) && (r_cyc == c_CYC_END);
    assign w_re_xfer   = r_re_vld && !o_dft_real_busy;
    assign w_im_xfer   = r_im_vld && !o_dft_imag_busy;
    assign w_bin_done  = (r_state == S_OUTPUT)
                       && !(r_re_vld && o_dft_real_busy)
                       && !(r_im_vld && o_dft_imag_busy);

    // ROM data in compute cycle c belongs to the address issued in cycle c-1,
    // so it pairs with sample x[c-1] (cycle N maps to x[N-1] via wrap).
    assign w_xidx        = r_cyc[LOG2N-1:0] - c_ONE;
    assign w_x_cur       = r_x[w_xidx];
    assign w_prod_re     = w_x_cur * i_tw_cos;
    assign w_prod_im     = w_x_cur * i_tw_sin;
    assign w_prod_re_ext = {{LOG2N{w_prod_re[c_PROD_W-1]}}, w_prod_re};
    assign w_prod_im_ext = {{LOG2N{w_prod_im[c_PROD_W-1]}}, w_prod_im};

    // Dropping the TW_W-1 fraction bits is an arithmetic floor shift; the
    // remaining upper bits are exactly OUT_W wide, so no saturation is needed.
    assign o_dft_real_data = r_acc_re[c_ACC_W-1:TW_W-1];
    assign o_dft_imag_data = r_acc_im[c_ACC_W-1:TW_W-1];
    assign w_unused        = ^{r_acc_re[TW_W-2:0], r_acc_im[TW_W-2:0]};

    assign i_real_busy    = r_busy;
    assign o_dft_real_vld = r_re_vld;
    assign o_dft_imag_vld = r_im_vld;
    assign o_bin_idx      = r_k;
    assign o_tw_addr      = r_addr;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_LOAD;
        else       r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:    if (w_last_load) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_comp_end)  w_state_next = S_OUTPUT;
            S_OUTPUT:  if (w_bin_done)  w_state_next = (r_k == c_LAST) ? S_LOAD : S_COMPUTE;
            default:                    w_state_next = S_LOAD;
        endcase
    end

    // Sample buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_in_xfer) r_x[r_cnt] <= i_real_data;
    end

    // Counters, twiddle address accumulator, MAC accumulators and output valids.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_k      <= '0;
            r_addr   <= '0;
            r_cyc    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_busy   <= 1'b0;
            r_re_vld <= 1'b0;
            r_im_vld <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_xfer) r_cnt <= r_cnt + c_ONE;
                    if (w_last_load) begin
                        r_busy <= 1'b1;
                        r_k    <= '0;
                        r_addr <= '0;
                        r_cyc  <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_cyc  <= r_cyc + 1'b1;
                    // Stepping by k each cycle yields k*n mod N without a multiplier.
                    r_addr <= r_addr + r_k;
                    if (r_cyc != '0) begin
                        r_acc_re <= r_acc_re + w_prod_re_ext;
                        r_acc_im <= r_acc_im - w_prod_im_ext;
                    end
                    if (w_comp_end) begin
                        r_cyc    <= '0;
                        r_addr   <= '0;
                        r_re_vld <= 1'b1;
                        r_im_vld <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (w_re_xfer) r_re_vld <= 1'b0;
                    if (w_im_xfer) r_im_vld <= 1'b0;
                    if (w_bin_done) begin
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        r_cyc    <= '0;
                        r_addr   <= '0;
                        if (r_k == c_LAST) begin
                            r_busy <= 1'b0;
                            r_cnt  <= '0;
                        end else begin
                            r_k <= r_k + c_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dft_compute_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dft_compute_stream
//  Description : Randomised self-checking bench for dft_compute_stream with a
//                direct-sum DFT reference model and an ideal Q1.15 ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dft_compute_stream;

    localparam int N      = 16;
    localparam int LOG2N  = 4;
    localparam int DATA_W = 16;
    localparam int TW_W   = 16;
    localparam int OUT_W  = DATA_W + LOG2N + 1;

    logic                     i_clk = 1'b0;
    logic                     i_rst = 1'b1;
    logic                     w_in_busy;
    logic                     r_in_vld = 1'b0;
    logic signed [DATA_W-1:0] r_in_data = '0;
    logic                     r_re_busy = 1'b0;
    logic                     w_re_vld;
    logic signed [OUT_W-1:0]  w_re_data;
    logic                     r_im_busy = 1'b0;
    logic                     w_im_vld;
    logic signed [OUT_W-1:0]  w_im_data;
    logic [LOG2N-1:0]         w_bin_idx;
    logic [LOG2N-1:0]         w_tw_addr;
    logic signed [TW_W-1:0]   r_tw_cos = '0;
    logic signed [TW_W-1:0]   r_tw_sin = '0;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cos_tab [N];
    int     sin_tab [N];
    int     x_frame [N];
    longint exp_re  [N];
    longint exp_im  [N];
    int     n_accepted = 0;
    bit     addr_mon_en = 1'b0;
    int     addr_q [$];

    dft_compute_stream #(
        .N(N), .LOG2N(LOG2N), .DATA_W(DATA_W), .TW_W(TW_W)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_real_busy     (w_in_busy),
        .i_real_vld      (r_in_vld),
        .i_real_data     (r_in_data),
        .o_dft_real_busy (r_re_busy),
        .o_dft_real_vld  (w_re_vld),
        .o_dft_real_data (w_re_data),
        .o_dft_imag_busy (r_im_busy),
        .o_dft_imag_vld  (w_im_vld),
        .o_dft_imag_data (w_im_data),
        .o_bin_idx       (w_bin_idx),
        .o_tw_addr       (w_tw_addr),
        .i_tw_cos        (r_tw_cos),
        .i_tw_sin        (r_tw_sin)
    );

    always #5 i_clk = ~i_clk;

    // Twiddle ROM with one cycle of read latency.
    always @(posedge i_clk) begin
        r_tw_cos <= TW_W'(cos_tab[w_tw_addr]);
        r_tw_sin <= TW_W'(sin_tab[w_tw_addr]);
    end

    // Counts every accepted input sample.
    always @(posedge i_clk) begin
        if (!i_rst && r_in_vld && !w_in_busy) n_accepted = n_accepted + 1;
    end

    // Records the twiddle addresses issued while bin 3 is being computed.
    always @(negedge i_clk) begin
        if (addr_mon_en && w_in_busy && !w_re_vld && !w_im_vld && w_bin_idx == 4'd3)
            addr_q.push_back(int'(w_tw_addr));
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int round_q(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Direct DFT sum using the same quantised twiddles the ROM holds.
    function automatic void build_model();
        for (int k = 0; k < N; k++) begin
            longint sr = 0;
            longint si = 0;
            for (int n = 0; n < N; n++) begin
                int idx = (k * n) % N;
                sr += longint'(x_frame[n]) * longint'(cos_tab[idx]);
                si -= longint'(x_frame[n]) * longint'(sin_tab[idx]);
            end
            exp_re[k] = sr >>> (TW_W - 1);
            exp_im[k] = si >>> (TW_W - 1);
        end
    endfunction

    function automatic void set_random_frame();
        for (int n = 0; n < N; n++) begin
            logic signed [DATA_W-1:0] s;
            s = DATA_W'($urandom);
            x_frame[n] = int'(s);
        end
    endfunction

    task automatic feed_frame(input bit gaps);
        int i = 0;
        int guard = 0;
        n_accepted = 0;
        while (i < N && guard < 2000) begin
            @(negedge i_clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                r_in_vld  = 1'b0;
                r_in_data = DATA_W'($urandom);
            end else begin
                r_in_vld  = 1'b1;
                r_in_data = DATA_W'(x_frame[i]);
                if (!w_in_busy) i++;
            end
        end
        if (i < N) check("feed_timeout", i, N);
    endtask

    // mode 0: no backpressure, 1: random stalls, 2: real stalled 5 cycles per bin
    task automatic collect(input int mode);
        bit     got_re [N];
        bit     got_im [N];
        bit     started [N];
        int     bins_done = 0;
        int     cyc = 0;
        int     last_rise = 0;
        int     re_hi = 0;
        bit     re_pend = 1'b0;
        bit     im_pend = 1'b0;
        longint re_hold = 0;
        longint im_hold = 0;
        for (int k = 0; k < N; k++) begin
            got_re[k] = 1'b0; got_im[k] = 1'b0; started[k] = 1'b0;
        end
        while (bins_done < N && cyc < 4000) begin
            @(negedge i_clk);
            cyc++;
            r_in_vld  = 1'b1;
            r_in_data = DATA_W'($urandom);
            case (mode)
                1:       begin r_re_busy = 1'($urandom_range(0, 1)); r_im_busy = 1'($urandom_range(0, 1)); end
                2:       begin r_re_busy = w_re_vld && (re_hi < 5);  r_im_busy = 1'b0; end
                default: begin r_re_busy = 1'b0; r_im_busy = 1'b0; end
            endcase
            if ((w_re_vld || w_im_vld) && !started[w_bin_idx]) begin
                started[w_bin_idx] = 1'b1;
                check("bin_order", w_bin_idx, bins_done);
                if (mode == 0) check("bin_latency", cyc - last_rise, N + 2);
                last_rise = cyc;
            end
            if (w_re_vld) begin
                re_hi++;
                check("re_repeat", got_re[w_bin_idx], 0);
                if (re_pend) check("re_stable", w_re_data, re_hold);
                re_hold = w_re_data;
                re_pend = r_re_busy;
                if (!r_re_busy) begin
                    check($sformatf("re_bin%0d", w_bin_idx), w_re_data, exp_re[w_bin_idx]);
                    got_re[w_bin_idx] = 1'b1;
                    re_hi = 0;
                end
            end else begin
                re_pend = 1'b0;
            end
            if (w_im_vld) begin
                check("im_repeat", got_im[w_bin_idx], 0);
                if (im_pend) check("im_stable", w_im_data, im_hold);
                im_hold = w_im_data;
                im_pend = r_im_busy;
                if (!r_im_busy) begin
                    check($sformatf("im_bin%0d", w_bin_idx), w_im_data, exp_im[w_bin_idx]);
                    got_im[w_bin_idx] = 1'b1;
                end
            end else begin
                im_pend = 1'b0;
            end
            if ((w_re_vld || w_im_vld) && got_re[w_bin_idx] && got_im[w_bin_idx]) bins_done++;
            if (bins_done < N) check("in_busy_during_frame", w_in_busy, 1);
        end
        if (bins_done < N) check("collect_timeout", bins_done, N);
        @(negedge i_clk);
        r_in_vld  = 1'b0;
        r_re_busy = 1'b0;
        r_im_busy = 1'b0;
        check("in_busy_released", w_in_busy, 0);
        check("samples_taken", n_accepted, N);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            cos_tab[i] = round_q(32767.0 * $cos(2.0 * 3.14159265358979 * i / N));
            sin_tab[i] = round_q(32767.0 * $sin(2.0 * 3.14159265358979 * i / N));
        end

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_re_vld", w_re_vld, 0);
        check("rst_im_vld", w_im_vld, 0);
        check("rst_in_busy", w_in_busy, 0);
        check("rst_re_data", w_re_data, 0);
        check("rst_im_data", w_im_data, 0);
        check("rst_bin_idx", w_bin_idx, 0);
        check("rst_tw_addr", w_tw_addr, 0);
        i_rst = 1'b0;

        // Impulse frame, no gaps, no backpressure; also capture k=3 addresses
        for (int n = 0; n < N; n++) x_frame[n] = 0;
        x_frame[0] = 1000;
        build_model();
        check("model_impulse_re", exp_re[5], 999);
        addr_q.delete();
        addr_mon_en = 1'b1;
        feed_frame(1'b0);
        collect(0);
        addr_mon_en = 1'b0;
        check("addr_count", addr_q.size(), N + 1);
        for (int n = 0; n < N && n < addr_q.size(); n++)
            check($sformatf("addr_k3_n%0d", n), addr_q[n], (3 * n) % N);

        // DC frame with random backpressure
        for (int n = 0; n < N; n++) x_frame[n] = 1000;
        build_model();
        check("model_dc_re0", exp_re[0], 15999);
        feed_frame(1'b1);
        collect(1);

        // Random samples, input gaps, random backpressure
        set_random_frame();
        build_model();
        feed_frame(1'b1);
        collect(1);

        // Random samples, real channel held busy 5 cycles per bin
        set_random_frame();
        build_model();
        feed_frame(1'b0);
        collect(2);

        // Reset in the middle of COMPUTE, then a fresh impulse frame
        set_random_frame();
        feed_frame(1'b0);
        @(negedge i_clk);
        r_in_vld = 1'b0;
        repeat (6) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst_re_vld", w_re_vld, 0);
        check("midrst_im_vld", w_im_vld, 0);
        check("midrst_in_busy", w_in_busy, 0);
        for (int n = 0; n < N; n++) x_frame[n] = 0;
        x_frame[0] = 1000;
        build_model();
        feed_frame(1'b0);
        collect(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
